// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier controller that borrows the pipeline ALU.
// Each RUN cycle feeds acc + mcand to the ALU and keeps the sum when the
// current multiplier bit is set. Leading zeros of the multiplier are
// skipped, so latency tracks the position of op_b's highest set bit.
module mul_sequencer #(
    parameter int          WIDTH     = 64,
    parameter logic [3:0]  ADD_CTRL  = 4'b0010,
    parameter logic [3:0]  IDLE_CTRL = 4'b0000,
    parameter int          CNT_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // A flush in IDLE or RUN cancels everything, including a same-edge start.
    logic accept;
    logic finish;
    logic step;

    assign accept = (state == IDLE) && start && !flush;
    assign finish = (state == RUN) && !flush &&
                    ((mplier == '0) || (cnt == CNT_W'(WIDTH)));
    assign step   = (state == RUN) && !flush && !finish;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN: begin
                if (flush)       next_state = IDLE;
                else if (finish) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand load on accept, one shift-add step per RUN cycle,
    // product capture on the RUN->DONE edge.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every datapath register is in the reset list; product must
        // read zero immediately when reset asserts mid-operation.
        if (!reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                acc    <= '0;
                mcand  <= op_a;
                mplier <= op_b;
                cnt    <= '0;
            end
            if (step) begin
                if (mplier[0]) acc <= alu_result;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) product <= acc;
        end
    end

    // Outputs: ALU is driven only in RUN; busy covers RUN and DONE.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = IDLE_CTRL;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN: begin
                alu_a    = acc;
                alu_b    = mcand;
                alu_ctrl = ADD_CTRL;
                busy     = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a cycle-count model computes
// busy/done/product/ALU drive from the operands, and directed runs pin the
// model with hand-computed products and done edges.
module tb_mul_sequencer;

    localparam int         WIDTH = 64;
    localparam logic [3:0] ADD   = 4'b0010;
    localparam logic [3:0] IDL   = 4'b0000;

    logic             clk;
    logic             reset;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;

    int checks = 0;
    int errors = 0;

    mul_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    // Stand-in for the shared pipeline ALU.
    assign alu_result = (alu_ctrl == ADD) ? alu_a + alu_b : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int k_of(input logic [63:0] b);
        int k = 0;
        for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Model: after an accepted start the unit stays busy for k+2 cycles;
    // the last of them is the done cycle, and the product a*b appears then.
    int          m_left;
    int          m_k;
    logic [63:0] m_a, m_b, m_prod;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_k    <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_prod <= '0;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                m_left <= k_of(op_b) + 2;
                m_k    <= k_of(op_b);
                m_a    <= op_a;
                m_b    <= op_b;
            end
        end else if (m_left == 1) begin
            m_left <= 0;
        end else if (flush) begin
            m_left <= 0;
        end else begin
            if (m_left == 2) m_prod <= m_a * m_b;
            m_left <= m_left - 1;
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin : cmp
        int          c;
        logic [63:0] mask, ea, eb;
        logic [3:0]  ec;
        if (reset === 1'b1) begin
            ea = '0; eb = '0; ec = IDL;
            if (m_left >= 2) begin
                // After c iterations acc holds a * (low c bits of b),
                // and mcand holds a << c.
                c    = m_k + 2 - m_left;
                mask = (c >= 64) ? '1 : ((64'd1 << c) - 64'd1);
                ea   = m_a * (m_b & mask);
                eb   = (c >= 64) ? '0 : (m_a << c);
                ec   = ADD;
            end
            check("busy",     64'(busy),     64'(m_left != 0));
            check("done",     64'(done),     64'(m_left == 1));
            check("product",  product,       m_prod);
            check("alu_ctrl", 64'(alu_ctrl), 64'(ec));
            check("alu_a",    alu_a,         ea);
            check("alu_b",    alu_b,         eb);
        end
    end

    // Start one multiply and wait for done; optionally pulse a second start
    // mid-run, which must be ignored.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_prod, input int exp_edge,
                          input bit inject);
        int n;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk); n++; #1;
            if (inject && n == 3) begin
                start = 1'b1; op_a = 64'd99; op_b = 64'd99;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 64'(n), 64'(exp_edge));
        end else begin
            check("done_edge", 64'(n), 64'(exp_edge));
            check("product_lit", product, exp_prod);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    64'(busy),     64'd0);
        check("rst_done",    64'(done),     64'd0);
        check("rst_product", product,       64'd0);
        check("rst_ctrl",    64'(alu_ctrl), 64'(IDL));
        reset = 1'b1;

        run_op(64'd3, 64'd5, 64'd15, 5, 1'b0);
        run_op(64'h1234, 64'd0, 64'd0, 2, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4, 1'b0);
        run_op(64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 66, 1'b0);
        run_op(64'd11, 64'd13, 64'd143, 6, 1'b1);
        run_op(64'd5, 64'd9, 64'd45, 6, 1'b0);    // back-to-back after done
        run_op(64'd3, 64'd5, 64'd15, 5, 1'b0);

        // Flush during the third RUN cycle of 7 * 0xFF.
        @(posedge clk); #1;
        start = 1'b1; op_a = 64'd7; op_b = 64'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy",    64'(busy), 64'd0);
        check("flush_product", product,   64'd15);
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_done", 64'(done), 64'd0);
        check("flush_hold",    product,   64'd15);

        // Asynchronous reset between edges during RUN.
        @(posedge clk); #1;
        start = 1'b1; op_a = 64'd7; op_b = 64'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_areset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("areset_busy",    64'(busy), 64'd0);
        check("areset_done",    64'(done), 64'd0);
        check("areset_product", product,   64'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        run_op(64'd6, 64'd7, 64'd42, 5, 1'b0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
